spi_frame_responder: RTL and testbench
======================================

// Module: spi_frame_responder
// PURPOSE
//  Motor-board end of the 12-word myo SPI frame. Sits behind a word-level SPI slave core.
//  Decodes the command words (SOF, pwmRef, controlFlags1/2, dummy).
//  Serves the status words (position hi/lo, velocity, current, spring, sensor1, sensor2).
//  Commits commands atomically at frame end; a watchdog zeroes the PWM reference if frames stop.
// PARAMETERS
//  SOF_WORD         16'h8000    required value of word 0
//  TX_IDLE_WORD     16'h0000    word transmitted in slots 0-4 and slots >=12
//  WATCHDOG_CYCLES  50_000_000  clocks without a valid frame before the watchdog expires; 0 = disabled
// PORTS
//  clock                input   1   system clock
//  reset_n              input   1   asynchronous reset, active-low
//  ss_n                 input   1   slave select, already synchronised to clock; low = frame active
//  rx_valid             input   1   one-cycle pulse: rx_word holds a completed received word
//  rx_word              input   16  received word, bit 15 = first bit on the wire
//  tx_req               input   1   one-cycle pulse: core requests the next transmit word
//  tx_word              output  16  transmit word for the core
//  tx_load              output  1   one-cycle pulse: tx_word is valid
//  position             input   32  actual position (signed)
//  velocity             input   16  actual velocity (signed)
//  current              input   16  actual current (signed)
//  spring_displacement  input   16  spring displacement (signed)
//  sensor1, sensor2     input   16  auxiliary sensors (signed)
//  pwm_ref              output  16  committed PWM reference (signed)
//  control_flags1       output  16  committed control flags word 1
//  control_flags2       output  16  committed control flags word 2
//  frame_valid          output  1   one-cycle pulse: a good frame was committed
//  frame_error          output  1   one-cycle pulse: a frame was rejected
//  watchdog_expired     output  1   level; set on timeout, cleared by the next valid frame
//  frame_count          output  16  count of good frames, wraps 0xFFFF->0
// BEHAVIOUR
//  Reset: all outputs, shadow registers, counters and snapshot = 0; FSM = IDLE.
//  Snapshot:
//   - Status inputs are registered every cycle while ss_n=1 and frozen while ss_n=0.
//   - All 7 status words of one frame are therefore coherent.
//  TX path:
//   - tx_idx is cleared on ss_n=1 and increments on each tx_req.
//   - tx_req in cycle n gives tx_load=1 and tx_word in cycle n+1.
//   - tx_word holds its value until the next load.
//   - idx 5 = position[31:16], 6 = position[15:0], 7 = velocity, 8 = current,
//     9 = spring_displacement, 10 = sensor1, 11 = sensor2.
//   - Any other idx = TX_IDLE_WORD.
//  RX path:
//   - rx_cnt is cleared on ss_n=1 and increments on each rx_valid (saturates at 13).
//   - Shadow registers are loaded on rx_valid in the FSM states below.
//  FSM:
//   - IDLE: ss_n=1. On ss_n falling, go to WAIT_SOF.
//   - WAIT_SOF: on rx_valid, rx_word==SOF_WORD -> CMD; otherwise -> BAD.
//   - CMD, words 1-4:
//     - rx_word[15]=1 -> BAD (bit 15 is reserved as the frame marker).
//     - Word 1 -> sh_pwm = {rx[14], rx[14:0]} (15-bit sign extension).
//     - Word 2 -> sh_f1; word 3 -> sh_f2; word 4 is discarded.
//     - After word 4 -> STATUS.
//   - STATUS, words 5-11: received data ignored. The 12th word -> FULL.
//   - FULL: any further rx_valid -> BAD (overrun).
//   - BAD: ignore all rx until ss_n rises. TX continues per the table above.
//  Frame end (ss_n 0->1), evaluated one cycle after the edge:
//   - FSM=FULL: pwm_ref/control_flags1/2 <= shadows in that cycle; frame_valid=1;
//     frame_count+1; watchdog counter cleared; watchdog_expired <= 0.
//   - rx_cnt=0 (select pulse with no words): no pulses, no change.
//   - Otherwise: frame_error=1; committed outputs unchanged.
//   - Then -> IDLE.
//  A rx_valid coinciding with the ss_n rise is counted before frame-end evaluation.
//  Watchdog (WATCHDOG_CYCLES != 0):
//   - A 32-bit counter increments every cycle and saturates at WATCHDOG_CYCLES.
//   - On reaching WATCHDOG_CYCLES: watchdog_expired=1 and pwm_ref forced to 0.
//   - Flags are kept.
//   - A later valid commit overrides the forced zero.
//  Asynchronous reset mid-frame: returns to reset state. The aborted frame gives no pulse.
//   The next frame is decoded normally once ss_n has been seen high.
// TESTING
//  1 Nominal: pwm 0x7FF6, f1 0x0003, f2 0x0000, position 0x12345678, velocity 0x00AB
//    -> tx idx5=0x1234, idx6=0x5678, idx7=0x00AB; frame_valid pulse; pwm_ref=0xFFF6,
//       control_flags1=0x0003, frame_count=1.
//  2 Word 0 = 0x8001 -> frame_error pulse; pwm_ref/flags unchanged; tx words 0-4=0.
//  3 SOF + 7 words, then ss_n rises -> frame_error; frame_count unchanged.
//  4 13-word frame -> 13th tx word=0x0000; frame_error; outputs unchanged.
//  5 WATCHDOG_CYCLES=100, pwm_ref=0x0010 committed, then no frames
//    -> at cycle 100 watchdog_expired=1, pwm_ref=0.
//    -> next nominal frame clears the flag and commits its pwm value.
//  6 reset_n low after word 3 -> all outputs 0; next full frame gives frame_valid, frame_count=1.
//  Bench also checks: position changed mid-frame (ss_n=0) -> tx words reflect the pre-frame value.

Source files
------------

// File: rtl/spi_frame_responder.sv
// Motor-board end of the 12-word myo SPI frame, sitting behind a word-level SPI slave core.
// Decodes command words, serves a frame-coherent status snapshot, commits commands at frame end.
module spi_frame_responder #(
  parameter logic [15:0] SOF_WORD        = 16'h8000,
  parameter logic [15:0] TX_IDLE_WORD    = 16'h0000,
  parameter int unsigned WATCHDOG_CYCLES = 50_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ss_n,
  input  logic        rx_valid,
  input  logic [15:0] rx_word,
  input  logic        tx_req,
  output logic [15:0] tx_word,
  output logic        tx_load,
  input  logic [31:0] position,
  input  logic [15:0] velocity,
  input  logic [15:0] current,
  input  logic [15:0] spring_displacement,
  input  logic [15:0] sensor1,
  input  logic [15:0] sensor2,
  output logic [15:0] pwm_ref,
  output logic [15:0] control_flags1,
  output logic [15:0] control_flags2,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        watchdog_expired,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SOF,
    S_CMD,
    S_STATUS,
    S_FULL,
    S_BAD
  } state_t;

  localparam logic [31:0] WD_LIMIT   = 32'(WATCHDOG_CYCLES);
  localparam logic [3:0]  RX_CNT_MAX = 4'd13;
  localparam logic [3:0]  TX_IDX_MAX = 4'd15;

  state_t      state, state_eff, state_rx, state_nx;
  logic        ss_n_q, ss_fall, ss_rise;
  logic [3:0]  rx_cnt, rx_cnt_inc, tx_idx;
  logic [31:0] snap_position;
  logic [15:0] snap_velocity, snap_current, snap_spring, snap_sensor1, snap_sensor2;
  logic [15:0] sh_pwm, sh_f1, sh_f2;
  logic        ld_pwm, ld_f1, ld_f2, commit, reject;
  logic [31:0] wd_cnt, wd_nx;
  logic        wd_hit;
  logic [15:0] tx_sel;

  assign ss_fall    = ~ss_n & ss_n_q;
  assign ss_rise    = ss_n & ~ss_n_q;
  assign rx_cnt_inc = (rx_valid && rx_cnt != RX_CNT_MAX) ? rx_cnt + 4'd1 : rx_cnt;

  // ss_n_q resets low so a select already active at reset release is never treated as a frame start
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ss_n_q        <= 1'b0;
      snap_position <= '0;
      snap_velocity <= '0;
      snap_current  <= '0;
      snap_spring   <= '0;
      snap_sensor1  <= '0;
      snap_sensor2  <= '0;
    end else begin
      ss_n_q <= ss_n;
      if (ss_n) begin
        snap_position <= position;
        snap_velocity <= velocity;
        snap_current  <= current;
        snap_spring   <= spring_displacement;
        snap_sensor1  <= sensor1;
        snap_sensor2  <= sensor2;
      end
    end
  end

  always_comb begin
    tx_sel = TX_IDLE_WORD;
    case (tx_idx)
      4'd5:    tx_sel = snap_position[31:16];
      4'd6:    tx_sel = snap_position[15:0];
      4'd7:    tx_sel = snap_velocity;
      4'd8:    tx_sel = snap_current;
      4'd9:    tx_sel = snap_spring;
      4'd10:   tx_sel = snap_sensor1;
      4'd11:   tx_sel = snap_sensor2;
      default: tx_sel = TX_IDLE_WORD;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tx_idx  <= '0;
      tx_word <= '0;
      tx_load <= 1'b0;
      rx_cnt  <= '0;
    end else begin
      tx_load <= tx_req;
      if (tx_req) tx_word <= tx_sel;
      if (ss_n) tx_idx <= '0;
      else if (tx_req && tx_idx != TX_IDX_MAX) tx_idx <= tx_idx + 4'd1;
      rx_cnt <= ss_n ? '0 : rx_cnt_inc;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  // A word arriving with the falling or rising select edge is decoded first,
  // so frame-end evaluation always sees it.
  always_comb begin
    ld_pwm    = 1'b0;
    ld_f1     = 1'b0;
    ld_f2     = 1'b0;
    commit    = 1'b0;
    reject    = 1'b0;
    state_eff = (state == S_IDLE && ss_fall) ? S_WAIT_SOF : state;
    state_rx  = state_eff;
    if (rx_valid) begin
      case (state_eff)
        S_WAIT_SOF: state_rx = (rx_word == SOF_WORD) ? S_CMD : S_BAD;
        S_CMD: begin
          if (rx_word[15]) begin
            state_rx = S_BAD;
          end else begin
            ld_pwm = (rx_cnt == 4'd1);
            ld_f1  = (rx_cnt == 4'd2);
            ld_f2  = (rx_cnt == 4'd3);
            if (rx_cnt == 4'd4) state_rx = S_STATUS;
          end
        end
        S_STATUS: if (rx_cnt == 4'd11) state_rx = S_FULL;
        S_FULL:   state_rx = S_BAD;
        default:  state_rx = state_eff;
      endcase
    end
    state_nx = state_rx;
    if (ss_rise) begin
      if (state_rx == S_FULL) commit = 1'b1;
      else if (state_rx != S_IDLE && rx_cnt_inc != '0) reject = 1'b1;
      state_nx = S_IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sh_pwm <= '0;
      sh_f1  <= '0;
      sh_f2  <= '0;
    end else begin
      if (ld_pwm) sh_pwm <= {rx_word[14], rx_word[14:0]};
      if (ld_f1)  sh_f1  <= rx_word;
      if (ld_f2)  sh_f2  <= rx_word;
    end
  end

  always_comb begin
    wd_nx = wd_cnt;
    if (commit) wd_nx = '0;
    else if (wd_cnt < WD_LIMIT) wd_nx = wd_cnt + 32'd1;
  end

  assign wd_hit = (WD_LIMIT != '0) && !commit && (wd_nx == WD_LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wd_cnt           <= '0;
      pwm_ref          <= '0;
      control_flags1   <= '0;
      control_flags2   <= '0;
      frame_valid      <= 1'b0;
      frame_error      <= 1'b0;
      watchdog_expired <= 1'b0;
      frame_count      <= '0;
    end else begin
      wd_cnt      <= wd_nx;
      frame_valid <= commit;
      frame_error <= reject;
      if (commit) begin
        pwm_ref          <= sh_pwm;
        control_flags1   <= sh_f1;
        control_flags2   <= sh_f2;
        frame_count      <= frame_count + 16'd1;
        watchdog_expired <= 1'b0;
      end else if (wd_hit) begin
        pwm_ref          <= '0;
        watchdog_expired <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_frame_responder.sv
// Self-checking bench for spi_frame_responder: directed vector table, corner sequences and
// randomized frames against a frame-level reference model.
module tb_spi_frame_responder;

  localparam int unsigned WD  = 100;
  localparam logic [15:0] SOF = 16'h8000;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ss_n = 1'b1;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_word = '0;
  logic        tx_req = 1'b0;
  logic [15:0] tx_word;
  logic        tx_load;
  logic [31:0] position = '0;
  logic [15:0] velocity = '0, current = '0, spring_displacement = '0, sensor1 = '0, sensor2 = '0;
  logic [15:0] pwm_ref, control_flags1, control_flags2, frame_count;
  logic        frame_valid, frame_error, watchdog_expired;

  int errors = 0;
  int checks = 0;
  bit rand_status = 1'b0;

  always #5 clock = ~clock;

  spi_frame_responder #(.SOF_WORD(SOF), .TX_IDLE_WORD(16'h0000), .WATCHDOG_CYCLES(WD)) dut (
    .clock(clock), .reset_n(reset_n), .ss_n(ss_n), .rx_valid(rx_valid), .rx_word(rx_word),
    .tx_req(tx_req), .tx_word(tx_word), .tx_load(tx_load), .position(position),
    .velocity(velocity), .current(current), .spring_displacement(spring_displacement),
    .sensor1(sensor1), .sensor2(sensor2), .pwm_ref(pwm_ref), .control_flags1(control_flags1),
    .control_flags2(control_flags2), .frame_valid(frame_valid), .frame_error(frame_error),
    .watchdog_expired(watchdog_expired), .frame_count(frame_count)
  );

  // Reference model: whole-frame bookkeeping, evaluated when the select is released.
  logic [15:0] m_snap[7];
  logic [15:0] m_words[$];
  logic [15:0] m_tx_word, m_pwm, m_f1, m_f2, m_cnt;
  logic        m_tx_load, m_fv, m_fe, m_exp, m_prev_ss, m_in_frame;
  int          m_tx_idx, m_wd;

  logic [15:0] tx_log[$];
  logic [15:0] fr[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_snap[i]) m_snap[i] = '0;
    m_words.delete();
    {m_tx_word, m_pwm, m_f1, m_f2, m_cnt} = '0;
    {m_tx_load, m_fv, m_fe, m_exp, m_prev_ss, m_in_frame} = '0;
    m_tx_idx = 0;
    m_wd = 0;
  endtask

  function automatic bit frame_ok();
    if (m_words.size() != 12 || m_words[0] != SOF) return 1'b0;
    for (int i = 1; i <= 4; i++) if (m_words[i][15]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit commit;
    commit = 1'b0;
    m_fv = 1'b0;
    m_fe = 1'b0;
    m_tx_load = tx_req;
    if (tx_req) m_tx_word = (m_tx_idx >= 5 && m_tx_idx <= 11) ? m_snap[m_tx_idx - 5] : 16'h0000;
    if (ss_n) m_tx_idx = 0;
    else if (tx_req) m_tx_idx++;
    if (ss_n) begin
      m_snap[0] = position[31:16];
      m_snap[1] = position[15:0];
      m_snap[2] = velocity;
      m_snap[3] = current;
      m_snap[4] = spring_displacement;
      m_snap[5] = sensor1;
      m_snap[6] = sensor2;
    end
    if (!ss_n && m_prev_ss) begin
      m_in_frame = 1'b1;
      m_words.delete();
    end
    if (m_in_frame && rx_valid) m_words.push_back(rx_word);
    if (ss_n && !m_prev_ss && m_in_frame) begin
      m_in_frame = 1'b0;
      if (m_words.size() != 0) begin
        if (frame_ok()) begin
          commit = 1'b1;
          m_pwm = {m_words[1][14], m_words[1][14:0]};
          m_f1 = m_words[2];
          m_f2 = m_words[3];
          m_cnt = m_cnt + 16'd1;
          m_fv = 1'b1;
          m_exp = 1'b0;
          m_wd = 0;
        end else begin
          m_fe = 1'b1;
        end
      end
    end
    m_prev_ss = ss_n;
    if (!commit && WD != 0 && m_wd < int'(WD)) begin
      m_wd++;
      if (m_wd == int'(WD)) begin
        m_exp = 1'b1;
        m_pwm = '0;
      end
    end
  endtask

  task automatic compare_all();
    chk("tx_load", tx_load, m_tx_load);
    chk("tx_word", tx_word, m_tx_word);
    chk("pwm_ref", pwm_ref, m_pwm);
    chk("control_flags1", control_flags1, m_f1);
    chk("control_flags2", control_flags2, m_f2);
    chk("frame_valid", frame_valid, m_fv);
    chk("frame_error", frame_error, m_fe);
    chk("watchdog_expired", watchdog_expired, m_exp);
    chk("frame_count", frame_count, m_cnt);
  endtask

  task automatic tick();
    if (rand_status) begin
      position = $urandom;
      velocity = 16'($urandom);
      current = 16'($urandom);
      spring_displacement = 16'($urandom);
      sensor1 = 16'($urandom);
      sensor2 = 16'($urandom);
    end
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
    if (tx_load) tx_log.push_back(tx_word);
    rx_valid = 1'b0;
    tx_req = 1'b0;
  endtask

  task automatic build_frame(input logic [15:0] w0, input logic [15:0] pw, input logic [15:0] f1,
                             input logic [15:0] f2, input int n);
    fr.delete();
    for (int i = 0; i < n; i++) begin
      case (i)
        0:       fr.push_back(w0);
        1:       fr.push_back(pw);
        2:       fr.push_back(f1);
        3:       fr.push_back(f2);
        default: fr.push_back(16'(i));
      endcase
    end
  endtask

  task automatic send_frame(input bit rnd, input bit merge, input bit do_mid, input logic [31:0] mid_pos);
    ss_n = 1'b0;
    tick();
    if (do_mid) position = mid_pos;
    tx_log.delete();
    for (int i = 0; i < fr.size(); i++) begin
      tx_req = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      tick();
      if (rnd) repeat ($urandom_range(0, 2)) tick();
      rx_valid = 1'b1;
      rx_word = fr[i];
      if (rnd) tx_req = 1'($urandom_range(0, 1));
      if (merge && i == fr.size() - 1) begin
        ss_n = 1'b1;
        tick();
        return;
      end
      tick();
    end
    ss_n = 1'b1;
    tick();
  endtask

  typedef struct {
    logic [15:0] w0;
    logic [15:0] pwm_w;
    logic [15:0] f1;
    logic [15:0] f2;
    int          nwords;
    logic [31:0] pos;
    logic [15:0] vel;
    bit          exp_valid;
    bit          exp_error;
    logic [15:0] exp_pwm;
    logic [15:0] exp_f1;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [15:0] r, w0;

    tbl[0] = '{16'h8000, 16'h7FF6, 16'h0003, 16'h0000, 12, 32'h12345678, 16'h00AB, 1'b1, 1'b0, 16'hFFF6, 16'h0003, 16'd1};
    tbl[1] = '{16'h8001, 16'h0111, 16'h0222, 16'h0333, 12, 32'h0F0F0F0F, 16'h0101, 1'b0, 1'b1, 16'hFFF6, 16'h0003, 16'd1};
    tbl[2] = '{16'h8000, 16'h0123, 16'h00A5, 16'h1111, 12, 32'hCAFEBABE, 16'h8001, 1'b1, 1'b0, 16'h0123, 16'h00A5, 16'd2};
    tbl[3] = '{16'h8000, 16'h0444, 16'h0555, 16'h0666, 8,  32'h01020304, 16'h0005, 1'b0, 1'b1, 16'h0123, 16'h00A5, 16'd2};
    tbl[4] = '{16'h8000, 16'h4000, 16'h7FFF, 16'h0001, 12, 32'h89ABCDEF, 16'h7FFF, 1'b1, 1'b0, 16'hC000, 16'h7FFF, 16'd3};
    tbl[5] = '{16'h8000, 16'h0777, 16'h0888, 16'h0999, 13, 32'h55556666, 16'h0042, 1'b0, 1'b1, 16'hC000, 16'h7FFF, 16'd3};

    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_pwm_ref", pwm_ref, 16'h0000);
    chk("reset_frame_count", frame_count, 16'h0000);
    chk("reset_tx_word", tx_word, 16'h0000);
    chk("reset_watchdog", watchdog_expired, 1'b0);
    reset_n = 1'b1;
    tick();

    foreach (tbl[k]) begin
      position = tbl[k].pos;
      velocity = tbl[k].vel;
      tick();
      build_frame(tbl[k].w0, tbl[k].pwm_w, tbl[k].f1, tbl[k].f2, tbl[k].nwords);
      send_frame(1'b0, 1'b0, 1'b0, '0);
      chk($sformatf("tbl%0d_frame_valid", k), frame_valid, tbl[k].exp_valid);
      chk($sformatf("tbl%0d_frame_error", k), frame_error, tbl[k].exp_error);
      chk($sformatf("tbl%0d_pwm_ref", k), pwm_ref, tbl[k].exp_pwm);
      chk($sformatf("tbl%0d_flags1", k), control_flags1, tbl[k].exp_f1);
      chk($sformatf("tbl%0d_frame_count", k), frame_count, tbl[k].exp_cnt);
      if (tbl[k].exp_valid) begin
        chk($sformatf("tbl%0d_tx5", k), tx_log[5], tbl[k].pos[31:16]);
        chk($sformatf("tbl%0d_tx6", k), tx_log[6], tbl[k].pos[15:0]);
        chk($sformatf("tbl%0d_tx7", k), tx_log[7], tbl[k].vel);
      end
      if (tbl[k].w0 != SOF)
        for (int i = 0; i < 5; i++) chk($sformatf("tbl%0d_tx%0d_idle", k, i), tx_log[i], 16'h0000);
      if (tbl[k].nwords == 13) chk($sformatf("tbl%0d_tx12_idle", k), tx_log[12], 16'h0000);
    end

    // Watchdog: expiry exactly WD cycles after the last commit, then recovery.
    build_frame(SOF, 16'h0010, 16'h0055, 16'h0066, 12);
    send_frame(1'b0, 1'b0, 1'b0, '0);
    chk("wd_commit_pwm", pwm_ref, 16'h0010);
    repeat (WD - 1) tick();
    chk("wd_before_expired", watchdog_expired, 1'b0);
    chk("wd_before_pwm", pwm_ref, 16'h0010);
    tick();
    chk("wd_at_expired", watchdog_expired, 1'b1);
    chk("wd_at_pwm", pwm_ref, 16'h0000);
    chk("wd_flags_kept", control_flags1, 16'h0055);
    build_frame(SOF, 16'h0020, 16'h0056, 16'h0066, 12);
    send_frame(1'b0, 1'b0, 1'b0, '0);
    chk("wd_recover_expired", watchdog_expired, 1'b0);
    chk("wd_recover_pwm", pwm_ref, 16'h0020);

    // Snapshot: status changed after the select falls must not reach the tx words.
    position = 32'hAAAA5555;
    tick();
    build_frame(SOF, 16'h0001, 16'h0002, 16'h0003, 12);
    send_frame(1'b0, 1'b0, 1'b1, 32'h0BADF00D);
    chk("snap_tx5", tx_log[5], 16'hAAAA);
    chk("snap_tx6", tx_log[6], 16'h5555);

    // Asynchronous reset after word 3 of a frame.
    build_frame(SOF, 16'h0101, 16'h0202, 16'h0303, 12);
    ss_n = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      tx_req = 1'b1;
      tick();
      rx_valid = 1'b1;
      rx_word = fr[i];
      tick();
    end
    reset_n = 1'b0;
    #1;
    chk("rst_pwm_ref", pwm_ref, 16'h0000);
    chk("rst_flags1", control_flags1, 16'h0000);
    chk("rst_flags2", control_flags2, 16'h0000);
    chk("rst_frame_count", frame_count, 16'h0000);
    chk("rst_tx_word", tx_word, 16'h0000);
    chk("rst_watchdog", watchdog_expired, 1'b0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    for (int i = 4; i < 12; i++) begin
      tx_req = 1'b1;
      tick();
      rx_valid = 1'b1;
      rx_word = fr[i];
      tick();
    end
    ss_n = 1'b1;
    tick();
    chk("abort_no_valid", frame_valid, 1'b0);
    chk("abort_no_error", frame_error, 1'b0);
    tick();
    send_frame(1'b0, 1'b0, 1'b0, '0);
    chk("post_rst_valid", frame_valid, 1'b1);
    chk("post_rst_count", frame_count, 16'd1);
    chk("post_rst_pwm", pwm_ref, 16'h0101);

    // Randomized frames against the model.
    rand_status = 1'b1;
    for (int it = 0; it < 60; it++) begin
      n = $urandom_range(0, 13);
      w0 = ($urandom_range(0, 4) == 0) ? 16'($urandom) : SOF;
      fr.delete();
      for (int i = 0; i < n; i++) begin
        r = 16'($urandom);
        if ($urandom_range(0, 5) != 0) r[15] = 1'b0;
        fr.push_back(i == 0 ? w0 : r);
      end
      repeat ($urandom_range(0, 4)) begin
        tx_req = 1'($urandom_range(0, 1));
        tick();
      end
      if (it == 30) repeat (WD + 20) tick();
      send_frame(1'b1, $urandom_range(0, 3) == 0, 1'b0, '0);
    end
    rand_status = 1'b0;
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
